divider_pipelined_param: RTL

//  Parametrised, fully pipelined signed/unsigned integer divider for the execute

---
 rtl/divider_pipelined_param.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/divider_pipelined_param.sv
// Fully pipelined signed/unsigned restoring divider, BITS_PER_STAGE quotient bits per stage.
// Optional output register stage: define DIVIDER_OUT_REG_EN.
module divider_pipelined_param #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_STAGE = 4,
    parameter int TAG_W          = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             i_valid,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_div_by_zero
);

    localparam int STAGES = WIDTH / BITS_PER_STAGE;
    localparam int LAST   = STAGES - 1;
    localparam int NB     = (STAGES > 1) ? STAGES - 1 : 1;

    if ((WIDTH % BITS_PER_STAGE) != 0 || WIDTH < 8 || (WIDTH % 2) != 0) begin : g_param_err
        $error("divider_pipelined_param: WIDTH must be even, >= 8 and a multiple of BITS_PER_STAGE");
    end

    // Front end: operand magnitudes and result sign flags
    logic             sign_a, sign_b, fe_dbz, fe_nq, fe_nr;
    logic [WIDTH-1:0] fe_a, fe_b;

    always_comb begin
        sign_a = is_signed & i_dividend[WIDTH-1];
        sign_b = is_signed & i_divisor[WIDTH-1];
        fe_dbz = (i_divisor == '0);
        fe_b   = sign_b ? -i_divisor : i_divisor;
        // With divisor 0 every step subtracts nothing, so the raw dividend
        // lands in the remainder and the quotient fills with ones.
        if (fe_dbz) begin
            fe_a  = i_dividend;
            fe_nq = 1'b0;
            fe_nr = 1'b0;
        end else begin
            fe_a  = sign_a ? -i_dividend : i_dividend;
            fe_nq = sign_a ^ sign_b;
            fe_nr = sign_a;
        end
    end

    // Per-stage state; aq holds unconsumed dividend bits on top, quotient bits shifting in below
    logic [STAGES-1:0] vld_q, nq_q, nr_q, dbz_q;
    logic [WIDTH-1:0]  r_q   [STAGES];
    logic [WIDTH-1:0]  aq_q  [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [WIDTH-1:0]  b_q   [NB];

    logic [WIDTH-1:0]  r_d   [STAGES];
    logic [WIDTH-1:0]  aq_d  [STAGES];
    logic [WIDTH-1:0]  b_cur;
    logic [WIDTH:0]    rt;

    always_comb begin
        rt    = '0;
        b_cur = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                r_d[k]  = '0;
                aq_d[k] = fe_a;
                b_cur   = fe_b;
            end else begin
                r_d[k]  = r_q[k-1];
                aq_d[k] = aq_q[k-1];
                b_cur   = b_q[k-1];
            end
            for (int unsigned i = 0; i < BITS_PER_STAGE; i++) begin
                rt = {r_d[k], aq_d[k][WIDTH-1]};
                if (rt >= {1'b0, b_cur}) begin
                    rt      = rt - {1'b0, b_cur};
                    aq_d[k] = {aq_d[k][WIDTH-2:0], 1'b1};
                end else begin
                    aq_d[k] = {aq_d[k][WIDTH-2:0], 1'b0};
                end
                r_d[k] = rt[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            nq_q  <= '0;
            nr_q  <= '0;
            dbz_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_q[k]   <= '0;
                aq_q[k]  <= '0;
                tag_q[k] <= '0;
            end
            for (int unsigned k = 0; k < NB; k++) begin
                b_q[k] <= '0;
            end
        end else if (!stall) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (k == 0) begin
                    vld_q[k] <= i_valid;
                    nq_q[k]  <= fe_nq;
                    nr_q[k]  <= fe_nr;
                    dbz_q[k] <= fe_dbz;
                    tag_q[k] <= i_tag;
                end else begin
                    vld_q[k] <= vld_q[k-1];
                    nq_q[k]  <= nq_q[k-1];
                    nr_q[k]  <= nr_q[k-1];
                    dbz_q[k] <= dbz_q[k-1];
                    tag_q[k] <= tag_q[k-1];
                end
                r_q[k]  <= r_d[k];
                aq_q[k] <= aq_d[k];
            end
            for (int unsigned k = 0; k < NB; k++) begin
                b_q[k] <= (k == 0) ? fe_b : b_q[k-1];
            end
        end
    end

    // Sign fix-up of the final stage
    logic [WIDTH-1:0] fx_q, fx_r;

    always_comb begin
        fx_q = nq_q[LAST] ? -aq_q[LAST] : aq_q[LAST];
        fx_r = nr_q[LAST] ? -r_q[LAST]  : r_q[LAST];
        if (dbz_q[LAST]) begin
            fx_q = '1;
        end
    end

`ifdef DIVIDER_OUT_REG_EN
    logic             ov_q, odbz_q;
    logic [WIDTH-1:0] oq_q, or_q;
    logic [TAG_W-1:0] otag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov_q   <= 1'b0;
            odbz_q <= 1'b0;
            oq_q   <= '0;
            or_q   <= '0;
            otag_q <= '0;
        end else if (!stall) begin
            ov_q   <= vld_q[LAST];
            odbz_q <= dbz_q[LAST];
            oq_q   <= fx_q;
            or_q   <= fx_r;
            otag_q <= tag_q[LAST];
        end
    end

    assign o_valid       = ov_q;
    assign o_quotient    = oq_q;
    assign o_remainder   = or_q;
    assign o_tag         = otag_q;
    assign o_div_by_zero = odbz_q;
`else
    assign o_valid       = vld_q[LAST];
    assign o_quotient    = fx_q;
    assign o_remainder   = fx_r;
    assign o_tag         = tag_q[LAST];
    assign o_div_by_zero = dbz_q[LAST];
`endif

endmodule
